// File: rtl/hazard_ctrl_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller.
//   hz_state_e    : mul/div sequencing FSM state (RUN, MD_BUSY)
//   FWD_RF/W/M    : operand forward-select encodings (2'b11 is never driven)
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;  // register file
  localparam logic [1:0] FWD_W  = 2'b01;  // ResultW
  localparam logic [1:0] FWD_M  = 2'b10;  // ALUResultM

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller signal bundle.
//   slave  modport : the hazard controller (register indices/enables in,
//                    forward selects, stall/flush controls, counters out)
//   master modport : the pipeline datapath (opposite directions)
interface hazard_ctrl_if;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E;
  logic [4:0]  RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic        ResultSrcE0, PCSrcE;
  logic        MulDivStartE, MulDivDoneE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE;
  logic        FlushD, FlushE, FlushM;
  logic [31:0] StallCount, FlushCount;

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
    input  MulDivStartE, MulDivDoneE,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output StallCount, FlushCount
  );

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE,
    output MulDivStartE, MulDivDoneE,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: forward-select comparator for one Execute source operand.
//   rs_i          : Execute source register index
//   rd_m_i/rd_w_i : Memory / Writeback destination indices
//   rw_m_i/rw_w_i : Memory / Writeback register write enables
//   fwd_o         : FWD_M, FWD_W or FWD_RF (Memory has priority)
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       rw_m_i,
  input  logic       rw_w_i,
  output logic [1:0] fwd_o
);

  // x0 is hard-wired zero, so a write to it never forwards.
  logic hit_m, hit_w;
  assign hit_m = rw_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_i);
  assign hit_w = rw_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_i);

  // Memory holds the younger result, so it wins over Writeback.
  always_comb begin
    fwd_o = FWD_RF;
    if (hit_m)      fwd_o = FWD_M;
    else if (hit_w) fwd_o = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RISC-V pipeline hazard unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   hz (slave) : register indices/enables, load/branch/muldiv status in;
//                ForwardAE/BE, StallF/D/E, FlushD/E/M, perf counters out
// Optional feature: define HAZARD_PERF_CNT_EN to build saturating
// StallCount/FlushCount counters; otherwise both ports are tied to 0.
// All outputs are gated to 0 while rst_n is low.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  // ---------------- forwarding ----------------
  logic [1:0] fwd_a, fwd_b;

  fwd_sel u_fwd_a (
    .rs_i   (hz.Rs1E),
    .rd_m_i (hz.RdM),
    .rd_w_i (hz.RdW),
    .rw_m_i (hz.RegWriteM),
    .rw_w_i (hz.RegWriteW),
    .fwd_o  (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs_i   (hz.Rs2E),
    .rd_m_i (hz.RdM),
    .rd_w_i (hz.RdW),
    .rw_m_i (hz.RegWriteM),
    .rw_w_i (hz.RegWriteW),
    .fwd_o  (fwd_b)
  );

  assign hz.ForwardAE = rst_n ? fwd_a : FWD_RF;
  assign hz.ForwardBE = rst_n ? fwd_b : FWD_RF;

  // ---------------- mul/div FSM ----------------
  // The unit latches operands in the start cycle, so once busy we only
  // wait for done. Done seen in RUN is ignored.
  hz_state_e state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (hz.MulDivStartE) state_q <= MD_BUSY;
        MD_BUSY: if (hz.MulDivDoneE)  state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // ---------------- stall / flush ----------------
  logic lw_stall, md_stall;
  logic stall_fd, flush_d, flush_e;

  assign lw_stall = hz.ResultSrcE0 && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // Stall starts in the issue cycle itself, before the FSM has moved.
  assign md_stall = ((state_q == RUN) && hz.MulDivStartE) ||
                    ((state_q == MD_BUSY) && !hz.MulDivDoneE);

  // A taken branch discards the younger instructions, so a load-use
  // stall behind it is pointless.
  assign stall_fd = rst_n && (lw_stall || md_stall) && !hz.PCSrcE;
  assign flush_d  = rst_n && hz.PCSrcE;
  // While Execute is frozen for mul/div, a bubble must not overwrite it.
  assign flush_e  = rst_n && (hz.PCSrcE || (lw_stall && !md_stall));

  assign hz.StallF = stall_fd;
  assign hz.StallD = stall_fd;
  assign hz.StallE = rst_n && md_stall;
  assign hz.FlushM = rst_n && md_stall;
  assign hz.FlushD = flush_d;
  assign hz.FlushE = flush_e;

  // ---------------- performance counters ----------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_fd && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_d  && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
`else
  assign hz.StallCount = 32'd0;
  assign hz.FlushCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// Counter values are checked only when HAZARD_PERF_CNT_EN is defined;
// otherwise both counters must read 0.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_stall = 0, exp_flush = 0;

  hazard_ctrl_if hz ();

  hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  // Start and taken branch must never coincide.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && hz.MulDivStartE === 1'b1 && hz.PCSrcE === 1'b1) begin
      bad++;
      $error("FAIL start_vs_branch observed=1 expected=0");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, 32'({hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM}),
        32'(exp));
  endtask

  task automatic chk_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_stallcnt"}, hz.StallCount, exp_stall);
    chk({tag, "_flushcnt"}, hz.FlushCount, exp_flush);
`else
    chk({tag, "_stallcnt"}, hz.StallCount, 32'd0);
    chk({tag, "_flushcnt"}, hz.FlushCount, 32'd0);
`endif
  endtask

  // Advance one clock; sf/fd are the StallF/FlushD values expected in the
  // cycle being closed, used to model the counters.
  task automatic tick(input logic sf, input logic fd);
    @(posedge clk);
    if (rst_n) begin
      if (sf && exp_stall != 32'hFFFF_FFFF) exp_stall++;
      if (fd && exp_flush != 32'hFFFF_FFFF) exp_flush++;
    end
    #1;
  endtask

  task automatic clr();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
    hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
    hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.ResultSrcE0 = 0; hz.PCSrcE = 0;
    hz.MulDivStartE = 0; hz.MulDivDoneE = 0;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    // Inputs that would forward, stall and flush if not held in reset.
    hz.RdM = 5; hz.RegWriteM = 1; hz.Rs1E = 5; hz.Rs2E = 5;
    hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs1D = 7; hz.PCSrcE = 1;
    tick(0, 0); tick(0, 0); #1;
    chk("rst_fwdA", 32'(hz.ForwardAE), 32'(2'b00));
    chk("rst_fwdB", 32'(hz.ForwardBE), 32'(2'b00));
    chk_ctl("rst_ctl", 6'b000000);
    chk_cnt("rst");
    clr();
    rst_n = 1'b1;
    tick(0, 0);

    // ---- forwarding ----
    hz.RdM = 5; hz.RegWriteM = 1; hz.RdW = 5; hz.RegWriteW = 1; hz.Rs1E = 5; hz.Rs2E = 5; #1;
    chk("fwdA_mem_wins", 32'(hz.ForwardAE), 32'(2'b10));
    chk("fwdB_mem_wins", 32'(hz.ForwardBE), 32'(2'b10));
    hz.RegWriteM = 0; #1;
    chk("fwdA_wb", 32'(hz.ForwardAE), 32'(2'b01));
    hz.Rs2E = 6; #1;
    chk("fwdB_nomatch", 32'(hz.ForwardBE), 32'(2'b00));
    hz.RdM = 0; hz.RdW = 0; hz.Rs1E = 0; hz.RegWriteM = 1; #1;
    chk("fwdA_x0", 32'(hz.ForwardAE), 32'(2'b00));
    chk_ctl("fwd_noctl", 6'b000000);
    clr(); tick(0, 0);

    // ---- load-use ----
    hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs2D = 7; #1;
    chk_ctl("lw_stall", 6'b110010);
    tick(1, 0);
    hz.ResultSrcE0 = 0; hz.RdE = 0; #1;
    chk_ctl("lw_bubble_done", 6'b000000);
    tick(0, 0);
    hz.Rs2D = 0; hz.Rs2E = 7; tick(0, 0);
    hz.RdW = 7; hz.RegWriteW = 1; #1;
    chk("lw_fwdB_wb", 32'(hz.ForwardBE), 32'(2'b01));
    chk_cnt("lw");
    clr(); tick(0, 0);
    hz.ResultSrcE0 = 1; hz.RdE = 0; hz.Rs1D = 0; #1;
    chk_ctl("lw_rd0", 6'b000000);
    clr(); tick(0, 0);

    // ---- branch overrides load-use ----
    hz.ResultSrcE0 = 1; hz.RdE = 9; hz.Rs1D = 9; hz.PCSrcE = 1; #1;
    chk_ctl("lw_branch", 6'b000110);
    tick(0, 1);
    clr(); #1;
    chk_cnt("lw_branch");
    tick(0, 0);

    // ---- mul/div, start at "cycle 10", done at "cycle 14" ----
    hz.MulDivStartE = 1; #1;
    chk_ctl("md_c10", 6'b111001);
    tick(1, 0);
    hz.MulDivStartE = 0; #1;
    chk_ctl("md_c11", 6'b111001);
    chk("md_busy_state", 32'(dut.state_q), 32'(MD_BUSY));
    tick(1, 0);
    hz.ResultSrcE0 = 1; hz.RdE = 3; hz.Rs1D = 3; #1;
    chk_ctl("md_c12_lw", 6'b111001);
    tick(1, 0);
    hz.ResultSrcE0 = 0; hz.RdE = 0; hz.Rs1D = 0; #1;
    chk_ctl("md_c13", 6'b111001);
    tick(1, 0);
    hz.MulDivDoneE = 1; #1;
    chk_ctl("md_c14_done", 6'b000000);
    tick(0, 0);
    hz.MulDivDoneE = 0; #1;
    chk("md_c15_run", 32'(dut.state_q), 32'(RUN));
    chk_ctl("md_c15", 6'b000000);
    chk_cnt("md");
    // done while idle is ignored
    hz.MulDivDoneE = 1; #1;
    chk_ctl("done_in_run", 6'b000000);
    tick(0, 0);
    hz.MulDivDoneE = 0; #1;
    chk("done_in_run_state", 32'(dut.state_q), 32'(RUN));
    tick(0, 0);

    // ---- reset in the middle of MD_BUSY ----
    hz.MulDivStartE = 1; tick(1, 0);
    hz.MulDivStartE = 0; tick(1, 0);
    rst_n = 1'b0; #1;
    chk_ctl("md_rst_ctl", 6'b000000);
    chk("md_rst_state", 32'(dut.state_q), 32'(RUN));
    exp_stall = 0; exp_flush = 0;
    chk_cnt("md_rst");
    tick(0, 0);
    rst_n = 1'b1; #1;
    chk_ctl("md_rst_rel1", 6'b000000);
    tick(0, 0);
    chk_ctl("md_rst_rel2", 6'b000000);
    chk_cnt("md_rst_rel");

`ifdef HAZARD_PERF_CNT_EN
    // ---- saturation ----
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_stall = 32'hFFFF_FFFE;
    hz.ResultSrcE0 = 1; hz.RdE = 4; hz.Rs1D = 4;
    tick(1, 0); tick(1, 0); tick(1, 0);
    chk("sat_stallcnt", hz.StallCount, 32'hFFFF_FFFF);
    clr();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
